// File: rtl/hack_ram_arbiter.sv
// Fixed-priority two-port arbiter for the single-port HACK data RAM.
// Port A wins by default; a wait counter forces a grant to B after MAX_WAIT denials.
module hack_ram_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [12:0] a_addr,
   input  logic [15:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [12:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [15:0] b_rdata,
   output logic [15:0] ram_data,
   output logic        ram_load,
   output logic [12:0] ram_address,
   input  logic [15:0] ram_out
);

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       rv_a_q, rv_a_d;
   logic       rv_b_q, rv_b_d;
   logic       force_b;

   // Grant decision: starved B overrides A's priority
   always_comb begin
      force_b = b_req && (wait_cnt_q == MAX_W);
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      if (!reset) begin
         if (force_b)    b_gnt = 1'b1;
         else if (a_req) a_gnt = 1'b1;
         else if (b_req) b_gnt = 1'b1;
      end
   end

   always_comb begin
      ram_address = a_addr;
      ram_data    = a_wdata;
      ram_load    = 1'b0;
      if (b_gnt) begin
         ram_address = b_addr;
         ram_data    = b_wdata;
         ram_load    = b_we;
      end else if (a_gnt) begin
         ram_load    = a_we;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!b_req || b_gnt)           wait_cnt_d = 8'd0;
      else if (wait_cnt_q != MAX_W)  wait_cnt_d = wait_cnt_q + 8'd1;
      rv_a_d = a_gnt && !a_we;
      rv_b_d = b_gnt && !b_we;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= 8'd0;
         rv_a_q     <= 1'b0;
         rv_b_q     <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rv_a_q     <= rv_a_d;
         rv_b_q     <= rv_b_d;
      end
   end

   // RAM output is already registered; only the valid flags are routed per port
   assign a_rvalid = rv_a_q & ~reset;
   assign b_rvalid = rv_b_q & ~reset;
   assign a_rdata  = ram_out;
   assign b_rdata  = ram_out;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a registered-output 8K x 16 RAM model.
module tb_hack_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [12:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic [15:0] ram_data;
   logic        ram_load;
   logic [12:0] ram_address;
   logic [15:0] ram_out;

   logic [15:0] mem [0:8191];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_load) mem[ram_address] <= ram_data;
      ram_out <= mem[ram_address];
   end

   hack_ram_arbiter #(.MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address),
      .ram_out(ram_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      repeat (2) next();
      settle();
      check("rst_a_gnt", a_gnt, 0);
      check("rst_b_gnt", b_gnt, 0);
      check("rst_load", ram_load, 0);
      check("rst_a_rv", a_rvalid, 0);
      check("rst_b_rv", b_rvalid, 0);
      check("rst_wait", dut.wait_cnt_q, 0);

      // A write then read of 0x0005
      next();
      reset = 0;
      a_req = 1; a_we = 1; a_addr = 13'h0005; a_wdata = 16'h1234;
      settle();
      check("aw_gnt", a_gnt, 1);
      check("aw_bgnt", b_gnt, 0);
      check("aw_load", ram_load, 1);
      check("aw_addr", ram_address, 13'h0005);
      check("aw_data", ram_data, 16'h1234);
      next();
      a_we = 0;
      settle();
      check("ar_gnt", a_gnt, 1);
      check("ar_load", ram_load, 0);
      check("ar_rv_after_write", a_rvalid, 0);
      next();
      a_req = 0;
      settle();
      check("ar_rv", a_rvalid, 1);
      check("ar_rdata", a_rdata, 16'h1234);
      check("ar_brv", b_rvalid, 0);
      check("idle_addr", ram_address, 13'h0005);
      check("idle_load", ram_load, 0);
      next();
      settle();
      check("ar_rv_drop", a_rvalid, 0);

      // Only B: write then read 0x1FFF
      b_req = 1; b_we = 1; b_addr = 13'h1FFF; b_wdata = 16'hBEEF;
      settle();
      check("bw_gnt", b_gnt, 1);
      check("bw_agnt", a_gnt, 0);
      check("bw_addr", ram_address, 13'h1FFF);
      check("bw_data", ram_data, 16'hBEEF);
      check("bw_load", ram_load, 1);
      next();
      b_we = 0;
      settle();
      check("br_gnt", b_gnt, 1);
      check("br_wait", dut.wait_cnt_q, 0);
      next();
      b_req = 0;
      settle();
      check("br_rv", b_rvalid, 1);
      check("br_rdata", b_rdata, 16'hBEEF);
      check("br_wait2", dut.wait_cnt_q, 0);
      check("br_arv", a_rvalid, 0);

      // Continuous contention: B wins every 5th cycle
      next();
      a_req = 1; a_we = 0; a_addr = 13'h0005;
      b_req = 1; b_we = 0; b_addr = 13'h1FFF;
      for (int k = 0; k < 10; k++) begin
         settle();
         check($sformatf("ct_bgnt%0d", k), b_gnt, (k % 5) == 4);
         check($sformatf("ct_agnt%0d", k), a_gnt, (k % 5) != 4);
         check($sformatf("ct_wait%0d", k), dut.wait_cnt_q, k % 5);
         check($sformatf("ct_arv%0d", k), a_rvalid, (k != 0) && ((k % 5) != 0));
         check($sformatf("ct_brv%0d", k), b_rvalid, (k % 5) == 0 && k != 0);
         if (k != 0 && (k % 5) == 0) check($sformatf("ct_bdat%0d", k), b_rdata, 16'hBEEF);
         if (k != 0 && (k % 5) != 0) check($sformatf("ct_adat%0d", k), a_rdata, 16'h1234);
         check($sformatf("ct_both%0d", k), a_rvalid & b_rvalid, 0);
         next();
      end
      a_req = 0; b_req = 0;
      settle();
      check("ct_tail_brv", b_rvalid, 1);
      check("ct_tail_bdat", b_rdata, 16'hBEEF);
      check("ct_tail_wait", dut.wait_cnt_q, 0);

      // Interleaved A read of 0x0000 then B read of 0x0001
      next();
      a_req = 1; a_we = 1; a_addr = 13'h0000; a_wdata = 16'h1111;
      next();
      a_req = 0;
      b_req = 1; b_we = 1; b_addr = 13'h0001; b_wdata = 16'h2222;
      next();
      b_req = 0; b_we = 0;
      a_req = 1; a_we = 0; a_addr = 13'h0000;
      settle();
      check("il_agnt", a_gnt, 1);
      next();
      a_req = 0;
      b_req = 1; b_addr = 13'h0001;
      settle();
      check("il_bgnt", b_gnt, 1);
      check("il_arv", a_rvalid, 1);
      check("il_adat", a_rdata, 16'h1111);
      check("il_brv0", b_rvalid, 0);
      next();
      b_req = 0;
      settle();
      check("il_brv", b_rvalid, 1);
      check("il_bdat", b_rdata, 16'h2222);
      check("il_arv0", a_rvalid, 0);
      next();

      // Reset in the cycle after an A read grant, with B waiting
      a_req = 1; a_we = 0; a_addr = 13'h0005; b_req = 1; b_we = 0;
      settle();
      check("rm_agnt0", a_gnt, 1);
      next();
      settle();
      check("rm_agnt1", a_gnt, 1);
      check("rm_wait1", dut.wait_cnt_q, 1);
      next();
      reset = 1; a_we = 1;
      settle();
      check("rm_agnt_rst", a_gnt, 0);
      check("rm_bgnt_rst", b_gnt, 0);
      check("rm_load_rst", ram_load, 0);
      check("rm_arv_rst", a_rvalid, 0);
      next();
      settle();
      check("rm_wait_rst", dut.wait_cnt_q, 0);
      check("rm_agnt_rst2", a_gnt, 0);
      check("rm_load_rst2", ram_load, 0);
      next();
      reset = 0; a_req = 0; b_req = 0; a_we = 0;
      settle();
      check("rm_arv_post", a_rvalid, 0);
      check("rm_wait_post", dut.wait_cnt_q, 0);

      // B drops its request after 3 denials, then re-requests
      next();
      a_req = 1; a_addr = 13'h0005; b_req = 1; b_addr = 13'h1FFF;
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("dr_bgnt%0d", k), b_gnt, 0);
         next();
      end
      b_req = 0;
      settle();
      check("dr_wait3", dut.wait_cnt_q, 3);
      check("dr_bgnt_off", b_gnt, 0);
      next();
      b_req = 1;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("rr_wait%0d", k), dut.wait_cnt_q, k);
         check($sformatf("rr_bgnt%0d", k), b_gnt, k == 4);
         check($sformatf("rr_agnt%0d", k), a_gnt, k != 4);
         next();
      end
      a_req = 0; b_req = 0;
      settle();
      check("rr_wait_clr", dut.wait_cnt_q, 0);
      check("rr_brv", b_rvalid, 1);
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
